// File: rtl/oam_dma_engine.sv
// Sprite DMA engine: a CPU write to $4014 halts the CPU and copies
// one 256-byte page into OAM, one byte per read/write cycle pair.
module oam_dma_engine #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int          ALIGN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic [7:0]  mem_data,
  output logic        cpu_halt,
  output logic        dma_mem_rd,
  output logic [15:0] dma_mem_addr,
  output logic        oam_dma,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_out,
  output logic        dma_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t     state_q;
  logic [7:0] page_q;
  logic [7:0] idx_q;
  logic [1:0] align_q;
  logic       parity_q;
  logic       trig;

  assign trig = cpu_wr && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      align_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      unique case (state_q)
        IDLE: begin
          if (trig) begin
            page_q  <= cpu_data_in;
            idx_q   <= '0;
            align_q <= 2'(ALIGN_CYCLES) + {1'b0, parity_q};
            state_q <= ALIGN;
          end
        end
        ALIGN: begin
          // a count of 0 or 1 both mean this is the last dummy cycle
          if (align_q <= 2'd1) begin
            state_q <= READ;
          end else begin
            align_q <= align_q - 2'd1;
          end
        end
        READ: begin
          state_q <= WRITE;
        end
        WRITE: begin
          idx_q   <= idx_q + 8'd1;
          state_q <= (idx_q == 8'hFF) ? IDLE : READ;
        end
      endcase
    end
  end

  assign cpu_halt     = (state_q != IDLE);
  assign dma_busy     = cpu_halt;
  assign dma_mem_rd   = (state_q == READ);
  assign dma_mem_addr = dma_mem_rd ? {page_q, idx_q} : 16'h0000;
  // read data arrives one cycle after READ, i.e. during WRITE
  assign oam_dma      = (state_q == WRITE);
  assign oam_addr     = oam_dma ? idx_q : 8'h00;
  assign oam_data_out = oam_dma ? mem_data : 8'h00;

endmodule
